fifo_rr_scheduler: RTL and testbench
====================================

Name: fifo_rr_scheduler

Overview:
- Credit-based round-robin scheduler that drains N input-port FIFOs into one shared downstream channel, e.g. a router output port feeding the next hop's input FIFO.
- Drives each upstream FIFO's read enable and muxes its registered read data into the downstream write interface.
- Upstream FIFO contract: read data is registered and valid the cycle after rd_en; empty flag is derived from the pointers.
- Optional wormhole packet lock holds a grant until the tail flit; tail is flagged by data MSB = 1.

Parameters:
N_REQ, 4, number of upstream FIFOs (>=2)
DATA_WIDTH, 8, flit width; bit DATA_WIDTH-1 is the tail/last flag
CREDITS, 3, downstream buffer slots (usable depth of the next FIFO)
LOCK_PKT, 1, 1 = hold grant until tail flit; 0 = re-arbitrate every flit

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
fifo_empty_i  input  N_REQ  per-FIFO empty flag
fifo_data_i  input  N_REQ*DATA_WIDTH  per-FIFO registered read data; slice k = FIFO k
fifo_rd_en_o  output  N_REQ  one-hot read enable (at most one bit set)
grant_o  output  N_REQ  one-hot current owner; 0 when idle
out_wr_en_o  output  1  downstream write strobe
out_data_o  output  DATA_WIDTH  downstream write data
credit_i  input  1  downstream freed one slot (its read pulse)
credit_err_o  output  1  sticky: credit returned while counter already at CREDITS

Behaviour:
- Reset (async, rst_ni=0): fifo_rd_en_o=0, grant_o=0, out_wr_en_o=0, out_data_o=0, credit_err_o=0, state=IDLE, rr_ptr=0, pending_q=0, owner=0, credit counter=CREDITS. Any in-flight flit is discarded.
- Eligibility: requester k is eligible when fifo_empty_i[k]=0 and credit counter > 0.
- Round-robin: search starts at rr_ptr and wraps modulo N_REQ. On a grant to k in IDLE, rr_ptr <= (k+1) mod N_REQ.
- Read latency: a read issued in cycle t sets pending_q. In t+1: out_wr_en_o=1 and out_data_o = slice[owner] of fifo_data_i. out_data_o=0 whenever out_wr_en_o=0.
- Credit counter: width clog2(CREDITS+1).
  - Decrement on each read issue; increment on credit_i; unchanged if both occur in the same cycle.
  - credit_i at CREDITS with no issue: counter stays, credit_err_o <= 1 (cleared only by reset).
  - Never issue a read when the counter is 0.
- States, LOCK_PKT=1:
  - IDLE: if any requester is eligible, pick k by round-robin, assert fifo_rd_en_o[k], owner <= k, pending_q <= 1, go to BUSY. The flit returned for a previous owner in this cycle is still written.
  - BUSY, pending_q=1, returned flit has last=1: write it, issue nothing, go to IDLE; grant_o=0 from the next cycle.
  - BUSY, pending_q=1, last=0: write it; in the same cycle issue the next read from owner if owner is non-empty and credit > 0. This gives full rate.
  - BUSY, pending_q=0: issue from owner when possible; owner keeps the grant regardless of other requesters.
  - grant_o = onehot(owner) while in BUSY.
- LOCK_PKT=0: stay in IDLE and arbitrate every cycle; last flag ignored; grant_o = onehot of the current issue, else 0.
- Boundary cases:
  - Owner FIFO empties mid-packet: hold BUSY and wait; no timeout.
  - Single requester: back-to-back issue every cycle while credits remain.
  - Credits reach 0 mid-packet: stall until credit_i.

Decomposition:
- Package noc_sched_pkg: state encoding (IDLE, BUSY), clog2 function, tail-bit index constant (DATA_WIDTH-1).
- Sub-module rr_arbiter: combinational N_REQ-way round-robin pick. Inputs: request vector, rr_ptr. Outputs: one-hot grant, index, any_grant.
- Scheduler top holds the FSM, credit counter and data mux.

Test Plan:
- Round-robin, N_REQ=4, LOCK_PKT=0, all FIFOs full of single-flit packets, credit_i tied so credits never drop -> out_wr_en_o every cycle; source order 0,1,2,3,0,...; first write at cycle 2 after reset release.
- Packet lock: FIFO1 holds 3 flits (tail on 3rd), FIFO2 holds 1 tail flit, both present at once -> three consecutive writes from FIFO1, one idle-issue cycle, then FIFO2's flit; grant_o=4'b0010 for the first three cycles.
- Credit exhaustion, CREDITS=3, no credit_i, FIFO0 holds 5 flits -> exactly 3 writes, then stall; one credit_i pulse -> exactly 1 more write.
- Simultaneous credit_i and issue at counter=1 -> counter stays 1; no stall on the next cycle.
- Spurious credit_i at counter=CREDITS -> credit_err_o=1 next cycle and stays 1 until reset.
- Reset asserted while BUSY with pending_q=1 -> all outputs 0 immediately; the in-flight flit is not written after release; the first grant after release goes to the lowest-index eligible FIFO.

Source files
------------

// File: rtl/noc_sched_pkg.sv
// Shared definitions for the credit-based round-robin FIFO scheduler.
//   state_e   : scheduler FSM encoding (IDLE, BUSY)
//   clog2     : ceiling log2, never below 1, so every index and counter is at least one bit wide
//   tail_bit  : position of the tail/last flag within a flit (its MSB)
package noc_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int DEF_DATA_WIDTH = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int tail_bit(input int data_width);
    return data_width - 1;
  endfunction

  localparam int DEF_TAIL_BIT = tail_bit(DEF_DATA_WIDTH);

endpackage

// File: rtl/fifo_rr_scheduler_rr_arbiter.sv
// Combinational N_REQ-way round-robin pick.
//   req_i  : request vector
//   ptr_i  : highest-priority index; the search wraps modulo N_REQ
//   gnt_o  : one-hot grant (0 if nothing requested)
//   idx_o  : binary index of the grant
//   any_o  : at least one request was granted
module rr_arbiter
  import noc_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req_i,
  input  logic [clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [clog2(N_REQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int PW = clog2(N_REQ);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    // Walk the requesters starting at ptr_i; the first hit wins.
    for (int i = 0; i < N_REQ; i++) begin
      int j;
      j = (int'(ptr_i) + i) % N_REQ;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = PW'(j);
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Credit-based round-robin scheduler draining N_REQ upstream FIFOs into one
// downstream write channel, with optional wormhole packet lock.
//   clk_i, rst_ni   : clock (rising edge), asynchronous active-low reset
//   fifo_empty_i    : per-FIFO empty flags
//   fifo_data_i     : per-FIFO registered read data (valid the cycle after rd_en)
//   fifo_rd_en_o    : one-hot read enable
//   grant_o         : one-hot current owner, 0 when idle
//   out_wr_en_o     : downstream write strobe
//   out_data_o      : downstream write data (0 when no write)
//   credit_i        : downstream freed one slot
//   credit_err_o    : sticky, a credit came back while the counter was full
module fifo_rr_scheduler
  import noc_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CREDITS    = 3,
  parameter int LOCK_PKT   = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [N_REQ-1:0]                  fifo_empty_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]  fifo_data_i,
  output logic [N_REQ-1:0]                  fifo_rd_en_o,
  output logic [N_REQ-1:0]                  grant_o,
  output logic                              out_wr_en_o,
  output logic [DATA_WIDTH-1:0]             out_data_o,
  input  logic                              credit_i,
  output logic                              credit_err_o
);

  localparam int PW   = clog2(N_REQ);
  localparam int CW   = clog2(CREDITS + 1);
  localparam int TAIL = tail_bit(DATA_WIDTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            pending_q, pending_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic            credit_err_q, credit_err_d;

  logic                  credit_ok;
  logic [N_REQ-1:0]      elig;
  logic [N_REQ-1:0]      arb_gnt;
  logic [PW-1:0]         arb_idx;
  logic                  arb_any;
  logic [N_REQ-1:0]      owner_oh;
  logic [DATA_WIDTH-1:0] flit;
  logic                  last_flit;
  logic                  issue;
  logic [N_REQ-1:0]      rd_en;
  logic [N_REQ-1:0]      gnt;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx == PW'(N_REQ - 1)) ? '0 : idx + PW'(1);
  endfunction

  assign credit_ok = (credit_q != '0);
  assign elig      = ~fifo_empty_i & {N_REQ{credit_ok}};

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    owner_oh = '0;
    owner_oh[owner_q] = 1'b1;
  end

  // The flit returned this cycle always belongs to owner_q: owner only
  // changes at the same edge that launches a new read.
  assign flit      = fifo_data_i[owner_q];
  assign last_flit = pending_q & flit[TAIL];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    issue    = 1'b0;
    rd_en    = '0;
    gnt      = '0;
    if (LOCK_PKT != 0) begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            issue    = 1'b1;
            rd_en    = arb_gnt;
            owner_d  = arb_idx;
            rr_ptr_d = next_ptr(arb_idx);
            state_d  = ST_BUSY;
          end
        end
        ST_BUSY: begin
          gnt = owner_oh;
          if (last_flit) begin
            state_d = ST_IDLE;
          end else if (!fifo_empty_i[owner_q] && credit_ok) begin
            // Issuing alongside the returned flit keeps the packet at full rate.
            issue = 1'b1;
            rd_en = owner_oh;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      if (arb_any) begin
        issue    = 1'b1;
        rd_en    = arb_gnt;
        gnt      = arb_gnt;
        owner_d  = arb_idx;
        rr_ptr_d = next_ptr(arb_idx);
      end
    end
  end

  assign pending_d = issue;

  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    unique case ({issue, credit_i})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CRED_MAX) credit_err_d = 1'b1;
        else                      credit_d     = credit_q + CW'(1);
      end
      default: ;
    endcase
  end

  // Combinational strobes are gated so nothing leaks out while reset is held.
  assign fifo_rd_en_o = rd_en & {N_REQ{rst_ni}};
  assign grant_o      = gnt & {N_REQ{rst_ni}};
  assign out_wr_en_o  = pending_q;
  assign out_data_o   = pending_q ? flit : '0;
  assign credit_err_o = credit_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      pending_q    <= 1'b0;
      credit_q     <= CRED_MAX;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      pending_q    <= pending_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench: dut_a runs with packet lock, dut_b re-arbitrates every flit.
// Each DUT reads from a small behavioural FIFO model with registered read data.
module tb_fifo_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N-1:0]    emp_a, rd_a, gnt_a, emp_b, rd_b, gnt_b;
  logic [N*DW-1:0] data_a, data_b;
  logic            wr_a, err_a, wr_b, err_b;
  logic            cr_a = 1'b0;
  logic            cr_b = 1'b0;
  logic [DW-1:0]   od_a, od_b;

  fifo_rr_scheduler #(.N_REQ(N), .DATA_WIDTH(DW), .CREDITS(3), .LOCK_PKT(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .fifo_empty_i(emp_a), .fifo_data_i(data_a),
    .fifo_rd_en_o(rd_a), .grant_o(gnt_a), .out_wr_en_o(wr_a), .out_data_o(od_a),
    .credit_i(cr_a), .credit_err_o(err_a)
  );

  fifo_rr_scheduler #(.N_REQ(N), .DATA_WIDTH(DW), .CREDITS(3), .LOCK_PKT(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .fifo_empty_i(emp_b), .fifo_data_i(data_b),
    .fifo_rd_en_o(rd_b), .grant_o(gnt_b), .out_wr_en_o(wr_b), .out_data_o(od_b),
    .credit_i(cr_b), .credit_err_o(err_b)
  );

  // FIFO models: the bench writes mem/wp, the model pops rp on rd_en.
  logic [DW-1:0] mem_a [N][64];
  logic [DW-1:0] mem_b [N][64];
  int            wp_a [N];
  int            rp_a [N];
  int            wp_b [N];
  int            rp_b [N];
  logic [DW-1:0] reg_a [N];
  logic [DW-1:0] reg_b [N];

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rd_a[k] && rp_a[k] != wp_a[k]) begin
        reg_a[k] <= mem_a[k][rp_a[k] % 64];
        rp_a[k]  <= rp_a[k] + 1;
      end
      if (rd_b[k] && rp_b[k] != wp_b[k]) begin
        reg_b[k] <= mem_b[k][rp_b[k] % 64];
        rp_b[k]  <= rp_b[k] + 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      emp_a[k] = (rp_a[k] == wp_a[k]);
      emp_b[k] = (rp_b[k] == wp_b[k]);
      data_a[k*DW +: DW] = reg_a[k];
      data_b[k*DW +: DW] = reg_b[k];
    end
  end

  task automatic push_a(input int k, input logic [DW-1:0] v);
    mem_a[k][wp_a[k] % 64] = v;
    wp_a[k] = wp_a[k] + 1;
  endtask

  task automatic push_b(input int k, input logic [DW-1:0] v);
    mem_b[k][wp_b[k] % 64] = v;
    wp_b[k] = wp_b[k] + 1;
  endtask

  task automatic start_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cr_a  = 1'b0;
    cr_b  = 1'b0;
    for (int k = 0; k < N; k++) begin
      wp_a[k] = rp_a[k];
      wp_b[k] = rp_b[k];
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    start_reset();
    push_a(0, 8'h01);
    push_b(0, 8'h81);
    #1;
    checks++; if (rd_a !== 4'b0)  begin errors++; $display("FAIL reset_rd_a got %b want 0000", rd_a); end
    checks++; if (gnt_a !== 4'b0) begin errors++; $display("FAIL reset_gnt_a got %b want 0000", gnt_a); end
    checks++; if (wr_a !== 1'b0)  begin errors++; $display("FAIL reset_wr_a got %b want 0", wr_a); end
    checks++; if (od_a !== 8'h00) begin errors++; $display("FAIL reset_od_a got %h want 00", od_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err_a got %b want 0", err_a); end
    checks++; if (rd_b !== 4'b0)  begin errors++; $display("FAIL reset_rd_b got %b want 0000", rd_b); end
    checks++; if (gnt_b !== 4'b0) begin errors++; $display("FAIL reset_gnt_b got %b want 0000", gnt_b); end
    checks++; if (wr_b !== 1'b0)  begin errors++; $display("FAIL reset_wr_b got %b want 0", wr_b); end
  endtask

  // All four FIFOs hold single-flit packets; credits returned every cycle.
  task automatic test_round_robin();
    logic [3:0]    e_rd;
    logic [DW-1:0] e_od;
    start_reset();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 8; j++) push_b(k, 8'h80 | 8'(k << 4) | 8'(j));
    cr_b = 1'b1;
    release_reset();
    #1;
    for (int c = 0; c < 13; c++) begin
      e_rd = 4'(1 << (c % 4));
      e_od = (c == 0) ? 8'h00 : (8'h80 | 8'(((c - 1) % 4) << 4) | 8'((c - 1) / 4));
      checks++; if (rd_b !== e_rd) begin errors++; $display("FAIL rr_rd c=%0d got %b want %b", c, rd_b, e_rd); end
      checks++; if (gnt_b !== e_rd) begin errors++; $display("FAIL rr_gnt c=%0d got %b want %b", c, gnt_b, e_rd); end
      checks++; if (wr_b !== (c != 0)) begin errors++; $display("FAIL rr_wr c=%0d got %b want %b", c, wr_b, c != 0); end
      checks++; if (od_b !== e_od) begin errors++; $display("FAIL rr_data c=%0d got %h want %h", c, od_b, e_od); end
      @(negedge clk); #1;
    end
    cr_b = 1'b0;
  endtask

  // FIFO1 carries a 3-flit packet, FIFO2 a single tail flit.
  task automatic test_packet_lock();
    logic [3:0]    e_rd  [7] = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h4, 4'h0, 4'h0};
    logic [3:0]    e_gnt [7] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4, 4'h0};
    logic          e_wr  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] e_od  [7] = '{8'h00, 8'h11, 8'h12, 8'h93, 8'h00, 8'hA1, 8'h00};
    start_reset();
    push_a(1, 8'h11); push_a(1, 8'h12); push_a(1, 8'h93);
    push_a(2, 8'hA1);
    release_reset();
    #1;
    for (int t = 0; t < 7; t++) begin
      cr_a = (t == 3);  // refills the credit spent on the third flit
      checks++; if (rd_a !== e_rd[t])   begin errors++; $display("FAIL lock_rd t=%0d got %b want %b", t, rd_a, e_rd[t]); end
      checks++; if (gnt_a !== e_gnt[t]) begin errors++; $display("FAIL lock_gnt t=%0d got %b want %b", t, gnt_a, e_gnt[t]); end
      checks++; if (wr_a !== e_wr[t])   begin errors++; $display("FAIL lock_wr t=%0d got %b want %b", t, wr_a, e_wr[t]); end
      checks++; if (od_a !== e_od[t])   begin errors++; $display("FAIL lock_data t=%0d got %h want %h", t, od_a, e_od[t]); end
      @(negedge clk); #1;
    end
    cr_a = 1'b0;
  endtask

  task automatic test_credit_exhaust();
    int n_first = 0;
    int n_second = 0;
    logic [3:0]    e_rd;
    logic          e_wr;
    logic [DW-1:0] e_od;
    start_reset();
    for (int j = 1; j <= 5; j++) push_a(0, 8'(j));
    release_reset();
    #1;
    for (int t = 0; t < 14; t++) begin
      cr_a = (t == 8);
      e_rd = (t <= 2 || t == 9) ? 4'b0001 : 4'b0000;
      e_wr = (t >= 1 && t <= 3) || (t == 10);
      e_od = (t >= 1 && t <= 3) ? 8'(t) : ((t == 10) ? 8'h04 : 8'h00);
      if (wr_a === 1'b1) begin
        if (t < 8) n_first++;
        else       n_second++;
      end
      checks++; if (rd_a !== e_rd) begin errors++; $display("FAIL cred_rd t=%0d got %b want %b", t, rd_a, e_rd); end
      checks++; if (wr_a !== e_wr) begin errors++; $display("FAIL cred_wr t=%0d got %b want %b", t, wr_a, e_wr); end
      checks++; if (od_a !== e_od) begin errors++; $display("FAIL cred_data t=%0d got %h want %h", t, od_a, e_od); end
      checks++; if (gnt_a !== ((t == 0) ? 4'b0000 : 4'b0001)) begin errors++; $display("FAIL cred_gnt t=%0d got %b", t, gnt_a); end
      @(negedge clk); #1;
    end
    cr_a = 1'b0;
    checks++; if (n_first !== 3)  begin errors++; $display("FAIL cred_writes_before got %0d want 3", n_first); end
    checks++; if (n_second !== 1) begin errors++; $display("FAIL cred_writes_after got %0d want 1", n_second); end
  endtask

  // Credit return coincides with an issue while the counter sits at 1.
  task automatic test_simul_credit();
    logic [3:0]    e_rd;
    logic          e_wr;
    logic [DW-1:0] e_od;
    start_reset();
    for (int j = 1; j <= 8; j++) push_a(0, 8'(j));
    release_reset();
    #1;
    for (int t = 0; t < 6; t++) begin
      cr_a = (t == 2);
      e_rd = (t <= 3) ? 4'b0001 : 4'b0000;
      e_wr = (t >= 1 && t <= 4);
      e_od = e_wr ? 8'(t) : 8'h00;
      checks++; if (rd_a !== e_rd) begin errors++; $display("FAIL simul_rd t=%0d got %b want %b", t, rd_a, e_rd); end
      checks++; if (wr_a !== e_wr) begin errors++; $display("FAIL simul_wr t=%0d got %b want %b", t, wr_a, e_wr); end
      checks++; if (od_a !== e_od) begin errors++; $display("FAIL simul_data t=%0d got %h want %h", t, od_a, e_od); end
      @(negedge clk); #1;
    end
    cr_a = 1'b0;
  endtask

  task automatic test_spurious_credit();
    start_reset();
    release_reset();
    #1;
    cr_a = 1'b1;
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL spur_before got %b want 0", err_a); end
    @(negedge clk); #1;
    cr_a = 1'b0;
    push_a(1, 8'h80);
    for (int t = 0; t < 5; t++) begin
      checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL spur_sticky t=%0d got %b want 1", t, err_a); end
      @(negedge clk); #1;
    end
    start_reset();
    #1;
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL spur_reset got %b want 0", err_a); end
  endtask

  // Reset lands while a read is in flight and after rr_ptr has moved past FIFO1.
  task automatic test_reset_inflight();
    start_reset();
    push_a(1, 8'h15); push_a(1, 8'h16);
    push_a(3, 8'h35);
    release_reset();
    #1;
    checks++; if (rd_a !== 4'b0010) begin errors++; $display("FAIL inflt_first_rd got %b want 0010", rd_a); end
    @(negedge clk); #1;
    checks++; if (od_a !== 8'h15) begin errors++; $display("FAIL inflt_first_data got %h want 15", od_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (rd_a !== 4'b0)  begin errors++; $display("FAIL inflt_rst_rd got %b want 0000", rd_a); end
    checks++; if (gnt_a !== 4'b0) begin errors++; $display("FAIL inflt_rst_gnt got %b want 0000", gnt_a); end
    checks++; if (wr_a !== 1'b0)  begin errors++; $display("FAIL inflt_rst_wr got %b want 0", wr_a); end
    checks++; if (od_a !== 8'h00) begin errors++; $display("FAIL inflt_rst_data got %h want 00", od_a); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (wr_a !== 1'b0)    begin errors++; $display("FAIL inflt_rel_wr got %b want 0", wr_a); end
    checks++; if (rd_a !== 4'b0010) begin errors++; $display("FAIL inflt_rel_rd got %b want 0010", rd_a); end
    @(negedge clk); #1;
    checks++; if (wr_a !== 1'b1)  begin errors++; $display("FAIL inflt_next_wr got %b want 1", wr_a); end
    checks++; if (od_a !== 8'h16) begin errors++; $display("FAIL inflt_next_data got %h want 16", od_a); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_credit_exhaust();
    test_simul_credit();
    test_spurious_credit();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
